// File: rtl/jtframe_joy_serial.sv
// jtframe_joy_serial
// Serial joystick reader for 74HC165-style parallel-in/serial-out chains
// (NeptUNO, MC2+). The chain is loaded with joy_load low. Each joy_clk pulse
// then shifts one bit out. The reader can run a second scan with joy_select
// low, which captures Mega Drive 6-button data.
//
// Ports:
//   clk        system clock (clk_sys)
//   rst        synchronous active-high reset
//   joy_data   serial data from the chain
//   joy_clk    shift clock to the chain
//   joy_load   parallel load to the chain, active-low
//   joy_select joystick select line
//   joy_out    latest committed input state, active-high (pressed=1)
//   joy_valid  one-cycle strobe, high on the cycle joy_out is committed
//
// Player p occupies scan bits [p*BITS +: BITS]. The first bit shifted out
// lands in the MSB, so the chain starts with the highest player index. With
// SELSCAN=1 the frame is {select-high scan, select-low scan}.
//
// Optional build macro JTFRAME_JOYSER_DEBOUNCE_EN: a completed frame commits
// only if it equals the previous completed frame.
//
// Every output is registered, so there is no combinational path from joy_data.
// Internal 'state' holds the scan state for debug visibility.
module jtframe_joy_serial #(
    parameter int PLAYERS = 2,
    parameter int BITS    = 8,
    parameter int DIV     = 4,
    parameter int GAP     = 16,
    parameter int SELSCAN = 0,
    parameter int INVERT  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 joy_data,
    output logic                                 joy_clk,
    output logic                                 joy_load,
    output logic                                 joy_select,
    output logic [PLAYERS*BITS*(SELSCAN+1)-1:0]  joy_out,
    output logic                                 joy_valid
);
    localparam int TOTAL = PLAYERS * BITS;
    localparam int OW    = TOTAL * (SELSCAN + 1);
    localparam int KW    = $clog2(TOTAL + 1);
    localparam bit SEL   = (SELSCAN != 0);
    localparam bit INV   = (INVERT != 0);

    localparam logic [15:0]   DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0]   GAP_LAST = 16'(GAP - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(TOTAL - 1);

    typedef enum logic [2:0] {
        ST_GAP,
        ST_LOAD,
        ST_SLOW,
        ST_SHIGH,
        ST_DONE
    } state_t;

    state_t          state, state_nx;
    logic [15:0]     timer, timer_nx;
    logic [KW-1:0]   k, k_nx;
    logic [TOTAL-1:0] scan;
    logic [OW-1:0]   frame;
    logic            sample_now;
    logic            done_entry;
    logic            frame_end;
    logic            accept;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx = state;
        timer_nx = timer + 16'd1;
        k_nx     = k;
        case (state)
            ST_GAP: begin
                if (timer == GAP_LAST) begin
                    state_nx = ST_LOAD;
                    timer_nx = '0;
                end
            end
            ST_LOAD: begin
                if (timer == DIV_LAST) begin
                    state_nx = ST_SLOW;
                    timer_nx = '0;
                    k_nx     = '0;
                end
            end
            ST_SLOW: begin
                if (timer == DIV_LAST) begin
                    state_nx = ST_SHIGH;
                    timer_nx = '0;
                end
            end
            ST_SHIGH: begin
                if (timer == DIV_LAST) begin
                    timer_nx = '0;
                    if (k == K_LAST) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_SLOW;
                        k_nx     = k + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_GAP;
                timer_nx = '0;
            end
            default: begin
                state_nx = ST_GAP;
                timer_nx = '0;
            end
        endcase
    end

    // The chain data is sampled on the last low cycle before the rising edge.
    assign sample_now = (state == ST_SLOW) && (timer == DIV_LAST);
    // The output registers follow state_nx, so the commit is made on the edge
    // that enters DONE. joy_valid and the new joy_out then appear together
    // on the DONE cycle.
    assign done_entry = (state_nx == ST_DONE) && (state != ST_DONE);
    // The select-high half of a two-scan update is only buffered.
    assign frame_end  = done_entry && !(SEL && joy_select);

    generate
        if (SEL) begin : g_sel
            logic [TOTAL-1:0] upper;
            always_ff @(posedge clk) begin
                if (rst) begin
                    upper <= '0;
                end else if (done_entry && joy_select) begin
                    upper <= scan;
                end
            end
            assign frame = {upper, scan};
        end else begin : g_nosel
            assign frame = scan;
        end
    endgenerate

`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    // The compare register holds the previous completed frame.
    logic [OW-1:0] cmp;
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp <= '0;
        end else if (frame_end) begin
            cmp <= frame;
        end
    end
    assign accept = (frame == cmp);
`else
    assign accept = 1'b1;
`endif

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_GAP;
            timer      <= '0;
            k          <= '0;
            scan       <= '0;
            joy_clk    <= 1'b0;
            joy_load   <= 1'b1;
            joy_select <= 1'b1;
            joy_out    <= '0;
            joy_valid  <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            k         <= k_nx;
            joy_clk   <= (state_nx == ST_SHIGH);
            joy_load  <= (state_nx != ST_LOAD);
            joy_valid <= frame_end && accept;
            if (frame_end && accept) begin
                joy_out <= frame;
            end
            if (done_entry && SEL) begin
                joy_select <= ~joy_select;
            end
            // Bit k of the shift sequence goes to scan[TOTAL-1-k].
            for (int i = 0; i < TOTAL; i++) begin
                if (sample_now && (k == KW'(TOTAL - 1 - i))) begin
                    scan[i] <= joy_data ^ INV;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtframe_joy_serial.sv
module tb_jtframe_joy_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: PLAYERS=2 BITS=8 DIV=2 GAP=4 SELSCAN=0
    logic        d0_data, d0_clk, d0_load, d0_sel, d0_valid;
    logic [15:0] d0_out;
    logic [15:0] par0 = 16'hA55A;
    // dut1: same timing, SELSCAN=1
    logic        d1_data, d1_clk, d1_load, d1_sel, d1_valid;
    logic [31:0] d1_out;
    // dut2: PLAYERS=1 BITS=1 DIV=1 GAP=1
    logic        d2_data, d2_clk, d2_load, d2_sel, d2_valid;
    logic [0:0]  d2_out;

    jtframe_joy_serial #(.PLAYERS(2), .BITS(8), .DIV(2), .GAP(4), .SELSCAN(0), .INVERT(1)) u_dut0 (
        .clk(clk), .rst(rst), .joy_data(d0_data), .joy_clk(d0_clk), .joy_load(d0_load),
        .joy_select(d0_sel), .joy_out(d0_out), .joy_valid(d0_valid));
    jtframe_joy_serial #(.PLAYERS(2), .BITS(8), .DIV(2), .GAP(4), .SELSCAN(1), .INVERT(1)) u_dut1 (
        .clk(clk), .rst(rst), .joy_data(d1_data), .joy_clk(d1_clk), .joy_load(d1_load),
        .joy_select(d1_sel), .joy_out(d1_out), .joy_valid(d1_valid));
    jtframe_joy_serial #(.PLAYERS(1), .BITS(1), .DIV(1), .GAP(1), .SELSCAN(0), .INVERT(1)) u_dut2 (
        .clk(clk), .rst(rst), .joy_data(d2_data), .joy_clk(d2_clk), .joy_load(d2_load),
        .joy_select(d2_sel), .joy_out(d2_out), .joy_valid(d2_valid));

    // ---------------- 74HC165 chain models ----------------
    logic [15:0] sr0, sr1;
    logic        sr2, par2;
    logic        pclk0, pclk1, pclk2;
    logic [15:0] par1;
    assign par1 = d1_sel ? 16'h00FF : 16'hF00F;

    always @(posedge clk) begin
        if (rst) begin
            sr0 <= '0; sr1 <= '0; sr2 <= 1'b0; par2 <= 1'b0;
            pclk0 <= 1'b0; pclk1 <= 1'b0; pclk2 <= 1'b0;
        end else begin
            pclk0 <= d0_clk; pclk1 <= d1_clk; pclk2 <= d2_clk;
            if (!d0_load) sr0 <= par0;
            else if (d0_clk && !pclk0) sr0 <= {sr0[14:0], 1'b0};
            if (!d1_load) sr1 <= par1;
            else if (d1_clk && !pclk1) sr1 <= {sr1[14:0], 1'b0};
            // dut2's chain presents new data on every load
            if (!d2_load) begin
                sr2  <= par2;
                par2 <= ~par2;
            end else if (d2_clk && !pclk2) begin
                sr2 <= 1'b0;
            end
        end
    end
    assign d0_data = sr0[15];
    assign d1_data = sr1[15];
    assign d2_data = sr2;

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge after the last reset edge (cycle 0).
    task automatic do_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset();
        n_checks += 8;
        if (d0_clk !== 1'b0)   begin n_fail++; $display("FAIL rst_clk got %b expected 0", d0_clk); end
        if (d0_load !== 1'b1)  begin n_fail++; $display("FAIL rst_load got %b expected 1", d0_load); end
        if (d0_sel !== 1'b1)   begin n_fail++; $display("FAIL rst_sel got %b expected 1", d0_sel); end
        if (d0_out !== 16'h0)  begin n_fail++; $display("FAIL rst_out got %h expected 0000", d0_out); end
        if (d0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b expected 0", d0_valid); end
        if (d1_sel !== 1'b1)   begin n_fail++; $display("FAIL rst_sel1 got %b expected 1", d1_sel); end
        if (d1_out !== 32'h0)  begin n_fail++; $display("FAIL rst_out1 got %h expected 0", d1_out); end
        if (d2_out !== 1'b0)   begin n_fail++; $display("FAIL rst_out2 got %b expected 0", d2_out); end
    endtask

    // Load/clock waveform, 71-cycle period and the 0xA55A chain pattern.
    task automatic test_timing;
        logic [15:0] exp_out;
        logic e_load, e_clk, e_valid;
        int p;
        par0 = 16'hA55A;
        do_reset();
        exp_out = 16'h0;
        for (int j = 1; j <= 142; j++) begin
            tick();
            p = j % 71;
            e_load  = !(p == 4 || p == 5);
            e_clk   = (p >= 6) && (p <= 69) && (((p - 6) % 4) >= 2);
            e_valid = (p == 70) && (!DEB || j >= 141);
            if (e_valid) exp_out = 16'h5AA5;
            n_checks += 4;
            if (d0_load !== e_load)   begin n_fail++; $display("FAIL tim_load j=%0d got %b expected %b", j, d0_load, e_load); end
            if (d0_clk !== e_clk)     begin n_fail++; $display("FAIL tim_clk j=%0d got %b expected %b", j, d0_clk, e_clk); end
            if (d0_valid !== e_valid) begin n_fail++; $display("FAIL tim_valid j=%0d got %b expected %b", j, d0_valid, e_valid); end
            if (d0_out !== exp_out)   begin n_fail++; $display("FAIL tim_out j=%0d got %h expected %h", j, d0_out, exp_out); end
        end
    endtask

    // Two scans per update; select toggles on every DONE.
    task automatic test_selscan;
        logic [31:0] exp_out;
        logic e_sel, e_valid;
        int p;
        do_reset();
        exp_out = 32'h0;
        for (int j = 1; j <= 290; j++) begin
            tick();
            p = j % 142;
            e_sel   = !(p >= 70 && p <= 140);
            e_valid = (p == 141) && (!DEB || j >= 283);
            if (e_valid) exp_out = 32'hFF00_0FF0;
            n_checks += 3;
            if (d1_sel !== e_sel)     begin n_fail++; $display("FAIL sel_select j=%0d got %b expected %b", j, d1_sel, e_sel); end
            if (d1_valid !== e_valid) begin n_fail++; $display("FAIL sel_valid j=%0d got %b expected %b", j, d1_valid, e_valid); end
            if (d1_out !== exp_out)   begin n_fail++; $display("FAIL sel_out j=%0d got %h expected %h", j, d1_out, exp_out); end
        end
    endtask

    // Reset during the 7th shift pulse of the third scan.
    task automatic test_reset_mid;
        logic [15:0] exp_out;
        logic e_valid;
        par0 = 16'hA55A;
        do_reset();
        repeat (174) tick();
        n_checks += 2;
        if (d0_clk !== 1'b1)     begin n_fail++; $display("FAIL mid_pulse got %b expected 1", d0_clk); end
        if (d0_out !== 16'h5AA5) begin n_fail++; $display("FAIL mid_before got %h expected 5aa5", d0_out); end
        rst  = 1'b1;
        par0 = 16'h0FF0;
        tick();
        n_checks += 5;
        if (d0_clk !== 1'b0)   begin n_fail++; $display("FAIL mid_clk got %b expected 0", d0_clk); end
        if (d0_load !== 1'b1)  begin n_fail++; $display("FAIL mid_load got %b expected 1", d0_load); end
        if (d0_sel !== 1'b1)   begin n_fail++; $display("FAIL mid_sel got %b expected 1", d0_sel); end
        if (d0_out !== 16'h0)  begin n_fail++; $display("FAIL mid_out got %h expected 0000", d0_out); end
        if (d0_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b expected 0", d0_valid); end
        rst = 1'b0;
        exp_out = 16'h0;
        for (int j = 1; j <= 142; j++) begin
            tick();
            e_valid = ((j % 71) == 70) && (!DEB || j >= 141);
            if (e_valid) exp_out = 16'hF00F;
            n_checks += 2;
            if (d0_valid !== e_valid) begin n_fail++; $display("FAIL mid_rvalid j=%0d got %b expected %b", j, d0_valid, e_valid); end
            if (d0_out !== exp_out)   begin n_fail++; $display("FAIL mid_rout j=%0d got %h expected %h", j, d0_out, exp_out); end
        end
    endtask

    // DIV=1 GAP=1 single bit: 5-cycle scans, data alternating every scan.
    task automatic test_small;
        logic e_out, e_valid, e_load;
        do_reset();
        e_out = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            e_load  = !((j % 5) == 1);
            e_valid = ((j % 5) == 4) && !DEB;
            if (e_valid) e_out = ~e_out;
            n_checks += 3;
            if (d2_load !== e_load)   begin n_fail++; $display("FAIL small_load j=%0d got %b expected %b", j, d2_load, e_load); end
            if (d2_valid !== e_valid) begin n_fail++; $display("FAIL small_valid j=%0d got %b expected %b", j, d2_valid, e_valid); end
            if (d2_out !== e_out)     begin n_fail++; $display("FAIL small_out j=%0d got %b expected %b", j, d2_out, e_out); end
        end
    endtask

    // One-scan glitch, then a new value held for two scans.
    task automatic test_glitch;
        logic [15:0] exp_out, loaded, prev, fr;
        logic e_valid;
        int p;
        par0 = 16'hA55A;
        do_reset();
        exp_out = 16'h0;
        prev    = 16'h0;
        loaded  = 16'h0;
        for (int j = 1; j <= 500; j++) begin
            tick();
            p = j % 71;
            if (p == 5) loaded = par0;
            e_valid = 1'b0;
            if (p == 70) begin
                fr      = ~loaded;
                e_valid = !DEB || (fr == prev);
                prev    = fr;
                if (e_valid) exp_out = fr;
            end
            n_checks += 2;
            if (d0_valid !== e_valid) begin n_fail++; $display("FAIL glitch_valid j=%0d got %b expected %b", j, d0_valid, e_valid); end
            if (d0_out !== exp_out)   begin n_fail++; $display("FAIL glitch_out j=%0d got %h expected %h", j, d0_out, exp_out); end
            if (j == 143) par0 = 16'h0000;
            if (j == 150) par0 = 16'hA55A;
            if (j == 356) par0 = 16'h1234;
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_selscan();
        test_reset_mid();
        test_small();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
